// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment bit order is g..a, active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Index 0 is the rightmost entry: digit 0 maps to 7'h40.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan with frame-aligned value commit,
// anti-ghost guard interval, leading-zero blanking and per-digit decimal point.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  digit;
  logic [15:0] shown;
  logic [15:0] pend_data;
  logic        pend;

  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic        lz;
  logic        xfer;
  logic        boundary;

  assign nib      = shown[{digit, 2'b00} +: 4];
  assign lz       = blank_lz && (digit != 2'd0) && ((shown >> {digit, 2'b00}) == 16'h0000);
  assign xfer     = load_valid & load_ready;
  assign boundary = en && (state == ST_ON) && (cnt == SLOT_LAST) && (digit == 2'd3);

  seg_decode u_decode (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      digit      <= 2'd0;
      shown      <= 16'h0000;
      pend_data  <= 16'h0000;
      pend       <= 1'b0;
      load_ready <= 1'b1;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      // Transfer needs pend clear and commit needs pend set, so they never collide.
      if (xfer) begin
        pend_data  <= load_data;
        pend       <= 1'b1;
        load_ready <= 1'b0;
      end
      if (pend && (state == ST_OFF || boundary)) begin
        shown      <= pend_data;
        pend       <= 1'b0;
        load_ready <= 1'b1;
      end

      if (!en) begin
        state <= ST_OFF;
        cnt   <= '0;
        digit <= 2'd0;
        seg   <= SEG_BLANK;
        an    <= AN_OFF;
        dp    <= 1'b1;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_GUARD;
            cnt   <= '0;
            digit <= 2'd0;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
            dp    <= 1'b1;
          end
          ST_GUARD: begin
            cnt <= cnt + CW'(1);
            if (cnt == GUARD_LAST) begin
              state <= ST_ON;
              an    <= ~(4'b0001 << digit);
              seg   <= lz ? SEG_BLANK : dec_seg;
              dp    <= ~dp_mask[digit];
            end
          end
          ST_ON: begin
            if (cnt == SLOT_LAST) begin
              state      <= ST_GUARD;
              cnt        <= '0;
              digit      <= digit + 2'd1;
              frame_tick <= (digit == 2'd3);
              seg        <= SEG_BLANK;
              an         <= AN_OFF;
              dp         <= 1'b1;
            end else begin
              // Refresh every cycle so dp_mask and blank_lz act live.
              cnt <= cnt + CW'(1);
              an  <= ~(4'b0001 << digit);
              seg <= lz ? SEG_BLANK : dec_seg;
              dp  <= ~dp_mask[digit];
            end
          end
          default: begin
            state <= ST_OFF;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
            dp    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-by-cycle comparison against a frame-timeline
// model plus directed checks of the display patterns.
module tb_seg_scan_ctrl;

  localparam int RDIV  = 8;
  localparam int GCYC  = 2;
  localparam int FRAME = 4 * RDIV;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  int n_eval;
  int n_fail;

  // Model: time since display enable, shown/pending values.
  bit          m_active;
  int          m_t;
  logic [15:0] m_shown;
  logic [15:0] m_pdata;
  bit          m_pend;
  bit          m_ready;
  bit          m_tick;

  seg_scan_ctrl #(.REFRESH_DIV(RDIV), .GUARD_CYC(GCYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_glyph(input int n);
    case (n)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit bnd;
    bit xf;
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_shown = 16'h0; m_pdata = 16'h0;
      m_pend = 0; m_ready = 1; m_tick = 0;
    end else begin
      bnd = en && m_active && ((m_t % FRAME) == FRAME - 1);
      xf  = load_valid && m_ready;
      if (m_pend && (bnd || !m_active)) begin
        m_shown = m_pdata; m_pend = 0; m_ready = 1;
      end
      if (xf) begin
        m_pdata = load_data; m_pend = 1; m_ready = 0;
      end
      m_tick = bnd;
      if (!en) m_active = 0;
      else if (!m_active) begin m_active = 1; m_t = 0; end
      else m_t++;
    end
  endtask

  // One clock: model sees the inputs present at the edge; outputs checked at negedge.
  task automatic step();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] upper;
    int d;
    @(posedge clk);
    model_edge();
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_active && (m_t % RDIV) >= GCYC) begin
      d = (m_t / RDIV) % 4;
      e_an  = ~(4'b0001 << d);
      upper = m_shown >> (4 * d);
      e_seg = (blank_lz && d > 0 && upper == 16'h0) ? 7'h7F : hex_glyph(int'(upper & 16'hF));
      e_dp  = ~dp_mask[d];
    end
    @(negedge clk);
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("load_ready", load_ready, m_ready);
    check("frame_tick", frame_tick, m_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    for (int i = 0; i < 3 * FRAME && an !== target; i++) step();
    check(tag, an, target);
  endtask

  initial begin
    n_eval = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    dp_mask = 4'h0; blank_lz = 1'b0;

    run(3);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_dp", dp, 1'b1);
    check("rst_ready", load_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);

    rst_n = 1'b1;
    run(5);
    check("off_hold_an", an, 4'hF);

    // 12AB committed while dark, then scanned.
    load_valid = 1'b1; load_data = 16'h12AB;
    step();
    load_valid = 1'b0;
    step();
    en = 1'b1;
    wait_an(4'b1110, "d0_12ab_an");
    check("d0_12ab_seg", seg, 7'b0000011);
    wait_an(4'b1011, "d2_12ab_an");
    check("d2_12ab_seg", seg, 7'b0100100);
    wait_an(4'b0111, "d3_12ab_an");
    check("d3_12ab_seg", seg, 7'b1111001);
    run(FRAME + 5);

    // Back-to-back loads; second waits for the frame boundary.
    load_valid = 1'b1; load_data = 16'h1111;
    step();
    check("b2b_ready_low", load_ready, 1'b0);
    load_data = 16'h2222;
    for (int i = 0; i < 3 * FRAME && load_ready !== 1'b1; i++) step();
    check("b2b_ready_at_tick", frame_tick, 1'b1);
    step();
    load_valid = 1'b0;
    run(2 * FRAME + 4);

    // Leading-zero blanking and decimal point.
    blank_lz = 1'b1;
    load_valid = 1'b1; load_data = 16'h0005;
    step();
    load_valid = 1'b0;
    run(FRAME);
    wait_an(4'b0111, "lz_d3_an");
    check("lz_d3_seg", seg, 7'h7F);
    wait_an(4'b1110, "lz_d0_an");
    check("lz_d0_seg", seg, 7'b0010010);
    load_valid = 1'b1; load_data = 16'h0000;
    step();
    load_valid = 1'b0;
    run(FRAME);
    wait_an(4'b1110, "zero_d0_an");
    check("zero_d0_seg", seg, 7'b1000000);
    dp_mask = 4'b0001;
    run(FRAME + 3);
    wait_an(4'b1110, "dp_d0_an");
    check("dp_d0", dp, 1'b0);

    // Disable in the middle of digit 2, then restart.
    wait_an(4'b1011, "dis_d2_an");
    step();
    en = 1'b0;
    step();
    check("dis_an", an, 4'hF);
    check("dis_seg", seg, 7'h7F);
    run(3);
    en = 1'b1;
    run(FRAME + 6);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                    {4{$urandom_range(0, 1) == 1}}, 4'hF};
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) == 0) en = ~en;
      if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      step();
    end
    load_valid = 1'b0; en = 1'b1; dp_mask = 4'h0; blank_lz = 1'b0;
    run(FRAME);

    // Reset mid-frame with pending data.
    load_valid = 1'b1; load_data = 16'h9876;
    run(2 * FRAME);
    wait_an(4'b1101, "rst_mid_an");
    check("rst_mid_pending", load_ready, 1'b0);
    load_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst_mid_seg", seg, 7'h7F);
    check("rst_mid_an_off", an, 4'hF);
    check("rst_mid_ready", load_ready, 1'b1);
    rst_n = 1'b1;
    run(2);
    wait_an(4'b1011, "post_rst_an");
    check("post_rst_seg", seg, 7'b1000000);
    check("post_rst_ready", load_ready, 1'b1);
    run(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
